counter_monitor: RTL and testbench

Checker and decoder placed directly downstream of the 3-bit up/Gray counter. It samples the counter's `count` and the `mode` and counter-reset signals that drove it. Each cycle it verifies that `count` is the legal successor of the previous sample. It also decodes `count` to a linear position, flags cycle wrap-arounds and keeps saturating wrap and error statistics. A three-state lock FSM tracks whether the counter is currently following a legal sequence.

---
 rtl/counter_monitor.sv | 186 ++++++++++++++++++
 tb/tb_counter_monitor.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/counter_monitor.sv
// Sequence checker and position decoder for a 3-bit binary/Gray up counter.
// Tracks lock status, flags wraps and keeps saturating wrap/error statistics.
module counter_monitor #(
  parameter int unsigned WRAP_W = 8,
  parameter int unsigned ERR_W  = 8,
  parameter int unsigned RELOCK = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              mode,
  input  logic              cnt_reset,
  input  logic [2:0]        count,
  input  logic              clear,
  output logic [2:0]        value,
  output logic              wrap_pulse,
  output logic [WRAP_W-1:0] wrap_count,
  output logic              error,
  output logic [ERR_W-1:0]  err_count,
  output logic [1:0]        state
);

  localparam int unsigned RL_W = 4;
  localparam logic [RL_W-1:0] RELOCK_L = RL_W'(RELOCK);

  typedef enum logic [1:0] {
    ST_SYNC   = 2'b00,
    ST_LOCKED = 2'b01,
    ST_FAULT  = 2'b10
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [2:0]        r_h_cnt;
  logic              r_h_mode;
  logic              r_h_cres;
  logic [RL_W-1:0]   r_relock;
  logic [RL_W-1:0]   w_relock_next;
  logic [2:0]        r_value;
  logic              r_wrap_pulse;
  logic [WRAP_W-1:0] r_wrap_cnt;
  logic              r_error;
  logic [ERR_W-1:0]  r_err_cnt;

  logic [2:0]        w_exp;
  logic              w_legal;
  logic              w_wrap;
  logic              w_illegal;
  logic [RL_W-1:0]   w_relock_inc;

  function automatic logic [2:0] gray_next(input logic [2:0] g);
    logic [2:0] n;
    case (g)
      3'b000:  n = 3'b001;
      3'b001:  n = 3'b011;
      3'b011:  n = 3'b010;
      3'b010:  n = 3'b110;
      3'b110:  n = 3'b111;
      3'b111:  n = 3'b101;
      3'b101:  n = 3'b100;
      default: n = 3'b000;
    endcase
    return n;
  endfunction

  function automatic logic [2:0] gray_to_bin(input logic [2:0] g);
    logic [2:0] b;
    b[2] = g[2];
    b[1] = b[2] ^ g[1];
    b[0] = b[1] ^ g[0];
    return b;
  endfunction

  // Expected successor is always derived from the previous sample's mode
  always_comb begin
    w_exp = 3'b000;
    if (r_h_cres) begin
      w_exp = 3'b000;
    end else if (!r_h_mode) begin
      w_exp = 3'(r_h_cnt + 3'd1);
    end else begin
      w_exp = gray_next(r_h_cnt);
    end
  end

  assign w_legal      = (count == w_exp);
  assign w_relock_inc = RL_W'(r_relock + RL_W'(1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_SYNC;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next  = r_state;
    w_relock_next = r_relock;
    w_wrap        = 1'b0;
    w_illegal     = 1'b0;
    case (r_state)
      ST_SYNC: begin
        w_state_next  = ST_LOCKED;
        w_relock_next = '0;
      end
      ST_LOCKED: begin
        if (w_legal) begin
          w_wrap = !r_h_cres && (count == 3'b000);
        end else begin
          w_illegal     = 1'b1;
          w_state_next  = ST_FAULT;
          w_relock_next = '0;
        end
      end
      ST_FAULT: begin
        if (w_legal) begin
          if (w_relock_inc >= RELOCK_L) begin
            w_state_next  = ST_LOCKED;
            w_relock_next = '0;
          end else begin
            w_relock_next = w_relock_inc;
          end
        end else begin
          w_illegal     = 1'b1;
          w_relock_next = '0;
        end
      end
      default: begin
        w_state_next  = ST_SYNC;
        w_relock_next = '0;
      end
    endcase
  end

  // History always follows the actual input so a faulted counter resyncs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_h_cnt  <= 3'b000;
      r_h_mode <= 1'b0;
      r_h_cres <= 1'b0;
      r_relock <= '0;
      r_value  <= 3'b000;
    end else begin
      r_h_cnt  <= count;
      r_h_mode <= mode;
      r_h_cres <= cnt_reset;
      r_relock <= w_relock_next;
      r_value  <= mode ? gray_to_bin(count) : count;
    end
  end

  // Statistics: clear overrides any same-edge event, pulse is unaffected
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wrap_pulse <= 1'b0;
      r_wrap_cnt   <= '0;
      r_error      <= 1'b0;
      r_err_cnt    <= '0;
    end else begin
      r_wrap_pulse <= w_wrap;
      if (clear) begin
        r_wrap_cnt <= '0;
        r_error    <= 1'b0;
        r_err_cnt  <= '0;
      end else begin
        if (w_wrap && (r_wrap_cnt != '1)) begin
          r_wrap_cnt <= WRAP_W'(r_wrap_cnt + WRAP_W'(1));
        end
        if (w_illegal) begin
          r_error <= 1'b1;
          if (r_err_cnt != '1) begin
            r_err_cnt <= ERR_W'(r_err_cnt + ERR_W'(1));
          end
        end
      end
    end
  end

  assign value      = r_value;
  assign wrap_pulse = r_wrap_pulse;
  assign wrap_count = r_wrap_cnt;
  assign error      = r_error;
  assign err_count  = r_err_cnt;
  assign state      = r_state;

endmodule

// File: tb/tb_counter_monitor.sv
// Directed self-checking bench for counter_monitor (ERR_W = 2, RELOCK = 2).
module tb_counter_monitor;

  localparam int unsigned WRAP_W = 8;
  localparam int unsigned ERR_W  = 2;
  localparam int unsigned RELOCK = 2;

  localparam logic [1:0] S_SYNC   = 2'b00;
  localparam logic [1:0] S_LOCKED = 2'b01;
  localparam logic [1:0] S_FAULT  = 2'b10;

  logic              clk = 1'b0;
  logic              reset;
  logic              mode;
  logic              cnt_reset;
  logic [2:0]        count;
  logic              clear;
  logic [2:0]        value;
  logic              wrap_pulse;
  logic [WRAP_W-1:0] wrap_count;
  logic              error;
  logic [ERR_W-1:0]  err_count;
  logic [1:0]        state;

  int total = 0;
  int bad   = 0;

  counter_monitor #(
    .WRAP_W(WRAP_W),
    .ERR_W (ERR_W),
    .RELOCK(RELOCK)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mode      (mode),
    .cnt_reset (cnt_reset),
    .count     (count),
    .clear     (clear),
    .value     (value),
    .wrap_pulse(wrap_pulse),
    .wrap_count(wrap_count),
    .error     (error),
    .err_count (err_count),
    .state     (state)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step(input logic [2:0] c, input logic m, input logic cr, input logic clr);
    count     = c;
    mode      = m;
    cnt_reset = cr;
    clear     = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_state"}, 32'(state), 32'(S_SYNC));
    chk({tag, "_value"}, 32'(value), 32'd0);
    chk({tag, "_wpulse"}, 32'(wrap_pulse), 32'd0);
    chk({tag, "_wcnt"}, 32'(wrap_count), 32'd0);
    chk({tag, "_err"}, 32'(error), 32'd0);
    chk({tag, "_ecnt"}, 32'(err_count), 32'd0);
  endtask

  initial begin
    logic [2:0] gseq [8];
    gseq = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};

    reset = 1'b1; mode = 1'b0; cnt_reset = 1'b0; count = 3'b000; clear = 1'b0;
    #1;
    chk_zero("rst");
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;

    // binary free-run 0..7,0
    step(3'd0, 1'b0, 1'b0, 1'b0);
    chk("bin_first_state", 32'(state), 32'(S_LOCKED));
    chk("bin_first_val", 32'(value), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(3'(i), 1'b0, 1'b0, 1'b0);
      chk("bin_val", 32'(value), 32'(i));
      chk("bin_nowrap", 32'(wrap_pulse), 32'd0);
    end
    step(3'd0, 1'b0, 1'b0, 1'b0);
    chk("bin_wrap_val", 32'(value), 32'd0);
    chk("bin_wrap_pulse", 32'(wrap_pulse), 32'd1);
    chk("bin_wrap_cnt", 32'(wrap_count), 32'd1);
    chk("bin_err", 32'(error), 32'd0);
    chk("bin_state", 32'(state), 32'(S_LOCKED));

    // Gray free-run from 000 (mode switch on the first step is legal)
    for (int i = 0; i < 8; i++) begin
      step(gseq[i], 1'b1, 1'b0, 1'b0);
      chk("gray_val", 32'(value), 32'((i + 1) % 8));
      chk("gray_pulse", 32'(wrap_pulse), (i == 7) ? 32'd1 : 32'd0);
    end
    chk("gray_wrap_cnt", 32'(wrap_count), 32'd2);
    chk("gray_err", 32'(error), 32'd0);
    chk("gray_state", 32'(state), 32'(S_LOCKED));

    // counter sync reset at 110, then binary continuation
    step(3'b001, 1'b1, 1'b0, 1'b0);
    step(3'b011, 1'b1, 1'b0, 1'b0);
    step(3'b010, 1'b1, 1'b0, 1'b0);
    step(3'b110, 1'b1, 1'b1, 1'b0);
    chk("cres_val", 32'(value), 32'd4);
    step(3'b000, 1'b1, 1'b0, 1'b0);
    chk("cres_nopulse", 32'(wrap_pulse), 32'd0);
    chk("cres_wcnt", 32'(wrap_count), 32'd2);
    chk("cres_err", 32'(error), 32'd0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    step(3'b010, 1'b0, 1'b0, 1'b0);
    step(3'b011, 1'b0, 1'b0, 1'b0);
    chk("mswitch_err", 32'(error), 32'd0);
    chk("mswitch_state", 32'(state), 32'(S_LOCKED));
    chk("mswitch_val", 32'(value), 32'd3);

    // fault after 010,011: illegal 110, then 111,000 relocks
    step(3'b110, 1'b0, 1'b0, 1'b0);
    chk("flt_state", 32'(state), 32'(S_FAULT));
    chk("flt_ecnt", 32'(err_count), 32'd1);
    chk("flt_err", 32'(error), 32'd1);
    step(3'b111, 1'b0, 1'b0, 1'b0);
    chk("flt_relock1", 32'(state), 32'(S_FAULT));
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk("flt_relock2", 32'(state), 32'(S_LOCKED));
    chk("flt_nopulse", 32'(wrap_pulse), 32'd0);
    chk("flt_wcnt", 32'(wrap_count), 32'd2);
    chk("flt_err_sticky", 32'(error), 32'd1);
    step(3'b001, 1'b0, 1'b0, 1'b1);
    chk("clr_err", 32'(error), 32'd0);
    chk("clr_ecnt", 32'(err_count), 32'd0);
    chk("clr_wcnt", 32'(wrap_count), 32'd0);
    chk("clr_state", 32'(state), 32'(S_LOCKED));

    // async reset mid-run while error is set
    step(3'b101, 1'b0, 1'b0, 1'b0);
    chk("pre_rst_err", 32'(error), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk_zero("arst");
    @(posedge clk);
    #1 reset = 1'b0;
    step(3'b101, 1'b0, 1'b0, 1'b0);
    chk("arst_first_state", 32'(state), 32'(S_LOCKED));
    chk("arst_first_err", 32'(error), 32'd0);
    chk("arst_first_val", 32'(value), 32'd5);
    step(3'b110, 1'b0, 1'b0, 1'b0);
    chk("arst_second_err", 32'(error), 32'd0);
    chk("arst_second_state", 32'(state), 32'(S_LOCKED));

    // err_count saturation at 3 (ERR_W = 2)
    for (int i = 1; i <= 5; i++) begin
      step(3'b110, 1'b0, 1'b0, 1'b0);
      chk("sat_ecnt", 32'(err_count), (i < 3) ? 32'(i) : 32'd3);
      chk("sat_state", 32'(state), 32'(S_FAULT));
    end
    step(3'b110, 1'b0, 1'b0, 1'b1);
    chk("sat_clr_ecnt", 32'(err_count), 32'd0);
    chk("sat_clr_err", 32'(error), 32'd0);
    chk("sat_clr_state", 32'(state), 32'(S_FAULT));

    // clear on the same edge as a wrap: pulse fires, count stays 0
    step(3'b111, 1'b0, 1'b0, 1'b0);
    step(3'b000, 1'b0, 1'b0, 1'b0);
    chk("cw_relock", 32'(state), 32'(S_LOCKED));
    chk("cw_nopulse", 32'(wrap_pulse), 32'd0);
    for (int i = 1; i < 8; i++) begin
      step(3'(i), 1'b0, 1'b0, 1'b0);
    end
    step(3'b000, 1'b0, 1'b0, 1'b1);
    chk("cw_pulse", 32'(wrap_pulse), 32'd1);
    chk("cw_wcnt", 32'(wrap_count), 32'd0);
    step(3'b001, 1'b0, 1'b0, 1'b0);
    chk("cw_pulse_drop", 32'(wrap_pulse), 32'd0);
    chk("cw_err", 32'(error), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
